// File: rtl/rgbi_palette_pipe.sv
// rgbi_palette_pipe: RGBI palette (LUT or linear product) with internal pixel divider
// and blank/sync delayed to stay aligned with the colour output.
module rgbi_palette_pipe #(
  parameter int CH    = 3,
  parameter int CH_W  = 4,
  parameter int I_W   = 4,
  parameter int OUT_W = 8,
  parameter int DIV   = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic [CH*CH_W-1:0]    pix_in,
  input  logic [I_W-1:0]        i_in,
  input  logic                  hblank_in,
  input  logic                  vblank_in,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  lut_wr,
  input  logic [CH_W+I_W-1:0]   lut_addr,
  input  logic [OUT_W-1:0]      lut_data,
  output logic                  lut_ready,
  output logic                  ce_pix,
  output logic [CH*OUT_W-1:0]   rgb_out,
  output logic                  hblank_out,
  output logic                  vblank_out,
  output logic                  hs_out,
  output logic                  vs_out
);
  localparam int AW = CH_W + I_W;
  localparam int CW = $clog2(DIV);
  localparam int KW = CH > 1 ? $clog2(CH) : 1;
  typedef enum logic [1:0] {IDLE, LOOK, COMMIT} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ce_q, ce_d;
  logic [KW-1:0] k_q, k_d;
  logic [CH*CH_W-1:0] pix_q, pix_d;
  logic [I_W-1:0] i_q, i_d;
  logic mode_q, mode_d;
  logic [3:0] tim_q, tim_d, tout_q, tout_d;
  logic [CH-1:0][OUT_W-1:0] stage_q, stage_d;
  logic [CH*OUT_W-1:0] rgb_q, rgb_d;
  logic pend_q, pend_d;
  logic [AW-1:0] paddr_q, paddr_d, waddr;
  logic [OUT_W-1:0] pdata_q, pdata_d, wdata, rd, prod, val;
  logic [OUT_W-1:0] lut_mem [2**AW];
  logic [CH_W-1:0] chan;
  logic acc, we, smp, last;
  always_comb begin
    cnt_d = cnt_q == CW'(DIV-1) ? '0 : cnt_q + 1'b1;
    ce_d = cnt_q == CW'(DIV-1);
    // a write accepted outside IDLE parks in the pending slot until the next IDLE cycle
    acc = lut_wr & ~pend_q;
    we = st_q == IDLE && (pend_q || acc);
    waddr = pend_q ? paddr_q : lut_addr;
    wdata = pend_q ? pdata_q : lut_data;
    pend_d = st_q != IDLE && (pend_q || acc);
    paddr_d = acc ? lut_addr : paddr_q;
    pdata_d = acc ? lut_data : pdata_q;
    chan = pix_q[k_q*CH_W +: CH_W];
    rd = lut_mem[{chan, i_q}];
    prod = (OUT_W'(chan) * OUT_W'(i_q)) << (OUT_W - AW);
    val = (i_q == '0 || tim_q[1:0] != '0) ? '0 : mode_q ? prod : rd;
    smp = st_q == IDLE && ce_q;
    last = st_q == LOOK && k_q == KW'(CH-1);
    st_d = smp ? LOOK : last ? COMMIT : st_q == COMMIT ? IDLE : st_q;
    k_d = smp ? '0 : st_q == LOOK ? k_q + 1'b1 : k_q;
    pix_d = smp ? pix_in : pix_q;
    i_d = smp ? i_in : i_q;
    mode_d = smp ? mode : mode_q;
    tim_d = smp ? {vs_in, hs_in, vblank_in, hblank_in} : tim_q;
    stage_d = stage_q;
    if (st_q == LOOK) stage_d[k_q] = val;
    // the last channel's read goes straight to the outputs so the update lands in COMMIT
    rgb_d = last ? stage_d : rgb_q;
    tout_d = last ? tim_q : tout_q;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      st_q <= IDLE;
      cnt_q <= '0;
      ce_q <= 1'b0;
      k_q <= '0;
      pix_q <= '0;
      i_q <= '0;
      mode_q <= 1'b0;
      tim_q <= '0;
      stage_q <= '0;
      rgb_q <= '0;
      tout_q <= 4'b0011;
      pend_q <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      ce_q <= ce_d;
      k_q <= k_d;
      pix_q <= pix_d;
      i_q <= i_d;
      mode_q <= mode_d;
      tim_q <= tim_d;
      stage_q <= stage_d;
      rgb_q <= rgb_d;
      tout_q <= tout_d;
      pend_q <= pend_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
    end
  end
  always_ff @(posedge clk_sys) if (we) lut_mem[waddr] <= wdata;
  assign lut_ready = ~pend_q;
  assign ce_pix = ce_q;
  assign rgb_out = rgb_q;
  assign {vs_out, hs_out, vblank_out, hblank_out} = tout_q;
endmodule
